// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITERS     = 32;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_MULT  = 3'b011;
    localparam logic [2:0] MD_DIV   = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on {HI,LO}.
// Multiply keeps the multiplier in the low half and shifts right; divide keeps {rem, dividend/quotient} and shifts left.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = '0;
        rem   = '0;
        diff  = '0;
        acc_o = acc_i;
        if (div_i) begin
            // Partial remainder shifted left by one, pulling in the next dividend bit.
            rem  = acc_i[2*WIDTH-1:WIDTH-1];
            diff = rem - {1'b0, opnd_i};
            if (rem >= {1'b0, opnd_i}) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: 32 RUN cycles + 1 DONE cycle, busy stalls the core; MTHI/MTLO take effect in one edge.
// MULDIV_SIGNED_EN enables signed MULT/DIV; without it they execute as MULTU/DIVU with identical latency.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERS);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, res;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic               div_q, div_d, done_q;
    logic               is_mul, is_div, accept_md;

    assign is_mul    = (md_op == MD_MULTU) || (md_op == MD_MULT);
    assign is_div    = (md_op == MD_DIVU) || (md_op == MD_DIV);
    assign accept_md = start && (state_q == ST_IDLE) && (is_mul || is_div);

`ifdef MULDIV_SIGNED_EN
    logic is_sgn, rs_neg, rt_neg, neg_q, rneg_q;

    assign is_sgn = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign rs_neg = is_sgn && rs_data[WIDTH-1];
    assign rt_neg = is_sgn && rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept_md) begin
            neg_q  <= rs_neg ^ rt_neg;
            rneg_q <= rs_neg;
        end
    end

    // Product/quotient follow the sign XOR; the remainder follows the dividend.
    always_comb begin
        res = acc_q;
        if (div_q) begin
            if (neg_q) begin
                res[WIDTH-1:0] = -acc_q[WIDTH-1:0];
            end
            if (rneg_q) begin
                res[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
            end
        end else if (neg_q) begin
            res = -acc_q;
        end
    end
`else
    assign rs_mag = rs_data;
    assign rt_mag = rt_data;
    assign res    = acc_q;
`endif

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_md) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, is_mul ? rt_mag : rs_mag};
                    opnd_d  = is_mul ? rs_mag : rt_mag;
                    div_d   = is_div;
                end else if (start && (md_op == MD_MTHI)) begin
                    hi_d = rs_data;
                end else if (start && (md_op == MD_MTLO)) begin
                    lo_d = rs_data;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d    = res[2*WIDTH-1:WIDTH];
                lo_d    = res[WIDTH-1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= (state_q == ST_DONE);
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
